// File: rtl/ppu_video_pkg.sv
// Shared VGA 640x480@60 timing constants and palette index type for the PPU video path.
package ppu_video_pkg;

    localparam int unsigned H_ACTIVE = 640;
    localparam int unsigned H_FP     = 16;
    localparam int unsigned H_SYNC   = 96;
    localparam int unsigned H_BP     = 48;
    localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

    localparam int unsigned V_ACTIVE = 480;
    localparam int unsigned V_FP     = 10;
    localparam int unsigned V_SYNC   = 2;
    localparam int unsigned V_BP     = 33;
    localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam int unsigned PAL_W    = 6;

    typedef logic [PAL_W-1:0] pal_idx_t;

    localparam pal_idx_t BLACK_IDX = 6'h0D;

endpackage

// File: rtl/ppu_line_ram.sv
// Simple dual-port line buffer: synchronous write, registered read (1-cycle latency).
// The MSB of each address selects the bank.
module ppu_line_ram #(
    parameter int unsigned AW = 9,
    parameter int unsigned DW = 6
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    localparam int unsigned DEPTH = 1 << AW;

    logic [DW-1:0] mem [DEPTH];

    // Write port and registered read port share the single clock.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/ppu_vga_scaler.sv
// Buffers PPU palette-index lines and scans them out 2x2 scaled, centred in 640x480@60 VGA.
// Optional build macro: VGA_SCANLINE_EN blanks odd VGA lines inside the image (scanline look).
module ppu_vga_scaler
    import ppu_video_pkg::*;
#(
    parameter int unsigned SRC_W     = 256,
    parameter int unsigned X_OFFSET  = 64,
    parameter pal_idx_t    BLACK_IDX = ppu_video_pkg::BLACK_IDX
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pix_valid,
    input  logic       pix_sol,
    input  logic [5:0] pix_idx,
    output logic [5:0] pal_idx,
    output logic       hsync_n,
    output logic       vsync_n,
    output logic       de,
    output logic       frame_start,
    output logic       ovf_sticky
);

    localparam int unsigned CW     = 10;
    localparam int unsigned SRC_AW = $clog2(SRC_W);
    localparam int unsigned RAM_AW = SRC_AW + 1;
    localparam int unsigned WX_W   = SRC_AW + 1;

    localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_ACT    = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_ACT    = CW'(V_ACTIVE);
    localparam logic [CW-1:0] HS_BEG   = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] HS_END   = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0] VS_BEG   = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] VS_END   = CW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [CW-1:0] IMG_BEG  = CW'(X_OFFSET);
    localparam logic [CW-1:0] IMG_END  = CW'(X_OFFSET + 2 * SRC_W);

    logic [CW-1:0]     h_cnt, v_cnt, v_next;
    logic              h_last, swap_pt, swap_do;
    logic              rd_bank, rd_bank_nx, wr_bank;
    logic [WX_W-1:0]   wr_x, wr_x_nx;
    logic              pending, pending_nx, ovf_nx;
    logic              we;
    logic [RAM_AW-1:0] waddr, rd_addr;
    logic [5:0]        ram_rdata;
    logic              de0, hs0, vs0, img0;
    logic              de1, hs1, vs1, img1;

    // Stage-0 decode: line-end/swap detection, sync/active windows and buffer read address.
    always_comb begin
        h_last     = (h_cnt == H_LAST);
        v_next     = (v_cnt == V_LAST) ? '0 : v_cnt + CW'(1);
        swap_pt    = h_last && !v_next[0] && (v_next < V_ACT);
        swap_do    = swap_pt && pending;
        rd_bank_nx = rd_bank ^ swap_do;
        wr_bank    = ~rd_bank_nx;
        de0        = (h_cnt < H_ACT) && (v_cnt < V_ACT);
        hs0        = !((h_cnt >= HS_BEG) && (h_cnt < HS_END));
        vs0        = !((v_cnt >= VS_BEG) && (v_cnt < VS_END));
        img0       = (h_cnt >= IMG_BEG) && (h_cnt < IMG_END) && (v_cnt < V_ACT);
`ifdef VGA_SCANLINE_EN
        img0       = img0 && !v_cnt[0];
`endif
        rd_addr    = {rd_bank, SRC_AW'((h_cnt - IMG_BEG) >> 1)};
    end

    // Write side: line capture into the bank not being displayed, completion and overflow tracking.
    always_comb begin
        we         = 1'b0;
        waddr      = {wr_bank, wr_x[SRC_AW-1:0]};
        wr_x_nx    = wr_x;
        pending_nx = pending && !swap_do;
        ovf_nx     = ovf_sticky;
        if (pix_valid && pix_sol) begin
            we      = 1'b1;
            waddr   = {wr_bank, SRC_AW'(0)};
            wr_x_nx = WX_W'(1);
            if (pending && !swap_do) begin
                ovf_nx     = 1'b1;
                pending_nx = 1'b0;
            end
        end else if (pix_valid && (wr_x < WX_W'(SRC_W))) begin
            we      = 1'b1;
            wr_x_nx = wr_x + WX_W'(1);
            if (wr_x == WX_W'(SRC_W - 1)) begin
                pending_nx = 1'b1;
            end
        end
    end

    // Raster counters; frame_start marks the cycle the counters sit at (0,0).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            h_cnt       <= '0;
            v_cnt       <= '0;
            frame_start <= 1'b0;
        end else begin
            h_cnt       <= h_last ? '0 : h_cnt + CW'(1);
            if (h_last) begin
                v_cnt <= v_next;
            end
            frame_start <= h_last && (v_cnt == V_LAST);
        end
    end

    // Bank ownership, write pointer and line-status flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_bank    <= 1'b0;
            wr_x       <= '0;
            pending    <= 1'b0;
            ovf_sticky <= 1'b0;
        end else begin
            rd_bank    <= rd_bank_nx;
            wr_x       <= wr_x_nx;
            pending    <= pending_nx;
            ovf_sticky <= ovf_nx;
        end
    end

    ppu_line_ram #(
        .AW (RAM_AW),
        .DW (6)
    ) u_line_ram (
        .clk   (clk),
        .we    (we),
        .waddr (waddr),
        .wdata (pix_idx),
        .raddr (rd_addr),
        .rdata (ram_rdata)
    );

    // Two-stage output pipeline keeping syncs and de aligned with the RAM read data.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            de1     <= 1'b0;
            hs1     <= 1'b1;
            vs1     <= 1'b1;
            img1    <= 1'b0;
            de      <= 1'b0;
            hsync_n <= 1'b1;
            vsync_n <= 1'b1;
            pal_idx <= BLACK_IDX;
        end else begin
            de1     <= de0;
            hs1     <= hs0;
            vs1     <= vs0;
            img1    <= img0;
            de      <= de1;
            hsync_n <= hs1;
            vsync_n <= vs1;
            pal_idx <= img1 ? ram_rdata : BLACK_IDX;
        end
    end

endmodule

// File: tb/tb_ppu_vga_scaler.sv
// Scoreboard bench for ppu_vga_scaler: expected raster outputs are queued per counter cycle
// and retired two cycles later against the DUT outputs.
module tb_ppu_vga_scaler;
    import ppu_video_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       pix_valid;
    logic       pix_sol;
    logic [5:0] pix_idx;
    logic [5:0] pal_idx;
    logic       hsync_n;
    logic       vsync_n;
    logic       de;
    logic       frame_start;
    logic       ovf_sticky;

    always #5 clk = ~clk;

    ppu_vga_scaler dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pix_valid   (pix_valid),
        .pix_sol     (pix_sol),
        .pix_idx     (pix_idx),
        .pal_idx     (pal_idx),
        .hsync_n     (hsync_n),
        .vsync_n     (vsync_n),
        .de          (de),
        .frame_start (frame_start),
        .ovf_sticky  (ovf_sticky)
    );

    typedef struct {
        int         h;
        int         v;
        logic       hs;
        logic       vs;
        logic       de;
        logic [5:0] pal;
        bit         pal_known;
    } exp_t;

    exp_t sbq[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Reference model of the raster position and the displayed / filling source lines.
    int         mh, mv, mwx;
    bit         mpend;
    bit         disp_known;
    logic [5:0] disp [256];
    logic [5:0] pend [256];

    function automatic exp_t expect_at(input int h, input int v);
        exp_t e;
        bit   img;
        e.h  = h;
        e.v  = v;
        e.hs = !(h >= 656 && h < 752);
        e.vs = !(v >= 490 && v < 492);
        e.de = (h < 640) && (v < 480);
        img  = (h >= 64) && (h < 576) && (v < 480);
`ifdef VGA_SCANLINE_EN
        if (v % 2 == 1) img = 1'b0;
`endif
        if (img) begin
            e.pal       = disp[(h - 64) / 2];
            e.pal_known = disp_known;
        end else begin
            e.pal       = 6'h0D;
            e.pal_known = 1'b1;
        end
        return e;
    endfunction

    // One clock: advance the model with the inputs sampled at this edge and queue the expectation.
    task automatic tick();
        bit         pv = pix_valid;
        bit         ps = pix_sol;
        bit         rs = rst_n;
        logic [5:0] pi = pix_idx;
        int         nv;
        @(posedge clk);
        #1;
        if (!rs) begin
            mh = 0; mv = 0; mwx = 0; mpend = 1'b0; disp_known = 1'b0;
            sbq.delete();
        end else begin
            if (mh == 799) begin
                mh = 0;
                nv = (mv == 524) ? 0 : mv + 1;
                if ((nv % 2 == 0) && (nv < 480) && mpend) begin
                    disp       = pend;
                    disp_known = 1'b1;
                    mpend      = 1'b0;
                end
                mv = nv;
            end else begin
                mh++;
            end
            if (pv && ps) begin
                pend[0] = pi;
                mwx     = 1;
                if (mpend) mpend = 1'b0;
            end else if (pv && mwx < 256) begin
                pend[mwx] = pi;
                if (mwx == 255) mpend = 1'b1;
                mwx++;
            end
        end
        sbq.push_back(expect_at(mh, mv));
    endtask

    // Retire the expectation for the counter value two cycles back.
    always @(negedge clk) begin
        exp_t e;
        if (sbq.size() == 3) begin
            e = sbq.pop_front();
            n_vec++;
            if (hsync_n !== e.hs || vsync_n !== e.vs || de !== e.de ||
                (e.pal_known && pal_idx !== e.pal)) begin
                n_err++;
                $display("FAIL scoreboard h=%0d v=%0d: got hs=%b vs=%b de=%b pal=%h, want hs=%b vs=%b de=%b pal=%h",
                         e.h, e.v, hsync_n, vsync_n, de, pal_idx, e.hs, e.vs, e.de, e.pal);
            end
        end
    end

    task automatic run_until(input int h, input int v);
        int n = 0;
        while (!(mh == h && mv == v) && n < 20000) begin
            tick();
            n++;
        end
        n_vec++;
        if (!(mh == h && mv == v)) begin
            n_err++;
            $display("FAIL run_until timeout: at h=%0d v=%0d, wanted h=%0d v=%0d", mh, mv, h, v);
        end
    endtask

    task automatic write_line(input int first, input int last, input bit konst, input logic [5:0] val);
        for (int i = first; i <= last; i++) begin
            pix_valid = 1'b1;
            pix_sol   = (i == 0);
            if (i >= 256)   pix_idx = 6'h3F;
            else if (konst) pix_idx = val;
            else            pix_idx = 6'(i);
            tick();
        end
        pix_valid = 1'b0;
        pix_sol   = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (5) tick();
        n_vec += 6;
        if (hsync_n !== 1'b1)     begin n_err++; $display("FAIL reset_hsync got %b want 1", hsync_n); end
        if (vsync_n !== 1'b1)     begin n_err++; $display("FAIL reset_vsync got %b want 1", vsync_n); end
        if (de !== 1'b0)          begin n_err++; $display("FAIL reset_de got %b want 0", de); end
        if (pal_idx !== 6'h0D)    begin n_err++; $display("FAIL reset_pal got %h want 0d", pal_idx); end
        if (ovf_sticky !== 1'b0)  begin n_err++; $display("FAIL reset_ovf got %b want 0", ovf_sticky); end
        if (frame_start !== 1'b0) begin n_err++; $display("FAIL reset_fs got %b want 0", frame_start); end
        rst_n = 1'b1;
    endtask

    task automatic test_scaling();
        logic [5:0] want;
        bit         chk;
        write_line(0, 255, 1'b0, 6'h00);
        while (!(mh == 0 && mv == 4)) begin
            tick();
            if (sbq.size() == 3 && sbq[0].v == 2) begin
                chk = 1'b1;
                case (sbq[0].h)
                    63:      want = 6'h0D;
                    64, 65:  want = 6'h00;
                    66, 67:  want = 6'h01;
                    575:     want = 6'h3F;
                    576:     want = 6'h0D;
                    default: chk = 1'b0;
                endcase
                if (chk) begin
                    n_vec++;
                    if (pal_idx !== want) begin
                        n_err++;
                        $display("FAIL scale_col%0d got %h want %h", sbq[0].h, pal_idx, want);
                    end
                end
                if (sbq[0].h == 0 || sbq[0].h == 640) begin
                    n_vec++;
                    if (de !== (sbq[0].h == 0)) begin
                        n_err++;
                        $display("FAIL latency_de_h%0d got %b want %b", sbq[0].h, de, sbq[0].h == 0);
                    end
                end
            end
        end
    endtask

    task automatic test_overflow();
        run_until(0, 4);
        write_line(0, 255, 1'b1, 6'h15);
        n_vec++;
        if (ovf_sticky !== 1'b0) begin n_err++; $display("FAIL ovf_before got %b want 0", ovf_sticky); end
        write_line(0, 0, 1'b1, 6'h2A);
        n_vec++;
        if (ovf_sticky !== 1'b1) begin n_err++; $display("FAIL ovf_on_sol got %b want 1", ovf_sticky); end
        write_line(1, 259, 1'b1, 6'h2A);
        while (!(mh == 0 && mv == 8)) begin
            tick();
            if (sbq.size() == 3 && (sbq[0].h == 64 || sbq[0].h == 575) && (sbq[0].v == 4 || sbq[0].v == 6)) begin
                n_vec++;
                if (sbq[0].v == 6 && pal_idx !== 6'h2A) begin
                    n_err++;
                    $display("FAIL ovf_second_line col%0d got %h want 2a", sbq[0].h, pal_idx);
                end
                if (sbq[0].v == 4 && pal_idx !== ((sbq[0].h == 64) ? 6'h00 : 6'h3F)) begin
                    n_err++;
                    $display("FAIL repeat_line col%0d got %h", sbq[0].h, pal_idx);
                end
            end
        end
        n_vec++;
        if (ovf_sticky !== 1'b1) begin n_err++; $display("FAIL ovf_sticky_hold got %b want 1", ovf_sticky); end
    endtask

    task automatic test_timing();
        int hs_low = 0, de_hi = 0, fs_hi = 0, last_fall = -1, period = 0;
        logic prev_hs = 1'b1;
        for (int i = 0; i < 1600; i++) begin
            tick();
            if (i >= 800) begin
                if (!hsync_n) hs_low++;
                if (de) de_hi++;
            end
            if (frame_start) fs_hi++;
            if (prev_hs && !hsync_n) begin
                if (last_fall >= 0) period = i - last_fall;
                last_fall = i;
            end
            prev_hs = hsync_n;
        end
        n_vec += 4;
        if (hs_low != 96)  begin n_err++; $display("FAIL hsync_width got %0d want 96", hs_low); end
        if (de_hi != 640)  begin n_err++; $display("FAIL de_per_line got %0d want 640", de_hi); end
        if (period != 800) begin n_err++; $display("FAIL hsync_period got %0d want 800", period); end
        if (fs_hi != 0)    begin n_err++; $display("FAIL frame_start_midframe got %0d want 0", fs_hi); end
    endtask

    task automatic test_reset_mid();
        logic [5:0] want;
        run_until(300, 10);
        rst_n = 1'b0;
        repeat (3) tick();
        n_vec += 3;
        if (ovf_sticky !== 1'b0) begin n_err++; $display("FAIL midreset_ovf got %b want 0", ovf_sticky); end
        if (de !== 1'b0)         begin n_err++; $display("FAIL midreset_de got %b want 0", de); end
        if (pal_idx !== 6'h0D)   begin n_err++; $display("FAIL midreset_pal got %h want 0d", pal_idx); end
        rst_n = 1'b1;
        write_line(0, 255, 1'b1, 6'h21);
        while (!(mh == 0 && mv == 4)) begin
            tick();
            if (sbq.size() == 3 && sbq[0].h == 100 && (sbq[0].v == 2 || sbq[0].v == 3)) begin
                want = 6'h21;
`ifdef VGA_SCANLINE_EN
                if (sbq[0].v == 3) want = 6'h0D;
`endif
                n_vec++;
                if (pal_idx !== want) begin
                    n_err++;
                    $display("FAIL after_reset_line%0d got %h want %h", sbq[0].v, pal_idx, want);
                end
            end
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        pix_valid  = 1'b0;
        pix_sol    = 1'b0;
        pix_idx    = 6'h00;
        mh         = 0;
        mv         = 0;
        mwx        = 0;
        mpend      = 1'b0;
        disp_known = 1'b0;
        test_reset();
        test_scaling();
        test_overflow();
        test_timing();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
